// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             clr_err;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side driving requests
  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with level, thresholds, sticky errors,
// registered read with valid strobe and synchronous flush.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sync_param_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [LW-1:0]    w_level_nxt;
  logic             w_ovf_set;
  logic             w_udf_set;

  // Accept decisions and next level; flush masks both requests
  always_comb begin
    w_wr_acc    = bus.wr_en && !r_full  && !bus.flush;
    w_rd_acc    = bus.rd_en && !r_empty && !bus.flush;
    w_ovf_set   = bus.wr_en && r_full  && !bus.flush;
    w_udf_set   = bus.rd_en && r_empty && !bus.flush;
    w_level_nxt = r_level;
    if (bus.flush) begin
      w_level_nxt = '0;
    end else begin
      w_level_nxt = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  // Pointers, level, registered status decode and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= (AF_LEVEL == 0);
      r_almost_empty <= 1'b1;
    end else begin
      r_level        <= w_level_nxt;
      r_full         <= (w_level_nxt == LW'(DEPTH));
      r_empty        <= (w_level_nxt == '0);
      r_almost_full  <= (32'(w_level_nxt) >= 32'(AF_LEVEL));
      r_almost_empty <= (32'(w_level_nxt) <= 32'(AE_LEVEL));
      r_rd_valid     <= w_rd_acc;
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_rd_acc) begin
          r_rptr    <= r_rptr + PW'(1);
          r_rd_data <= r_mem[r_rptr];
        end
      end
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_set) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 8-bit single-mode FIFO in the tt_um_fifo design.
- Generalises data width and depth.
- Adds level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, registered read with valid strobe, and a synchronous flush.
- Instantiated inside the top-level user project and driven from ui_in/uio_in; status is exported on uo_out/uio_out.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL.
- LW (localparam), $clog2(DEPTH)+1, width of level.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents and state.
- clr_err  in  1  synchronous clear of overflow/underflow.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data, registered.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  LW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is asynchronous assert, active-low; de-assertion is assumed synchronised externally.
- Reset values:
  - Pointers = 0, level = 0, rd_data = 0, rd_valid = 0.
  - full = 0, empty = 1, almost_full = (AF_LEVEL == 0), almost_empty = 1.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Status outputs: full, empty, almost_full and almost_empty are decoded from the registered level only; there is no combinational path from wr_en or rd_en to any output.
- Write acceptance:
  - Accepted iff wr_en && !full, where full is sampled at the start of the cycle.
  - On accept: mem[wptr] <= wr_data; wptr increments modulo DEPTH.
- Read acceptance:
  - Accepted iff rd_en && !empty.
  - On accept: rd_data <= mem[rptr] at the same edge, so data appears 1 cycle after rd_en; rd_valid = 1 for exactly that cycle; rptr increments modulo DEPTH.
  - With no accepted read: rd_valid = 0 and rd_data holds its previous value.
- Simultaneous read and write:
  - Not full and not empty: both accepted, level unchanged.
  - Full: read accepted, write dropped, overflow set. Level becomes DEPTH-1.
  - Empty: write accepted, read dropped, underflow set. rd_valid = 0; the written word is NOT forwarded.
- Level update: level_next = level + wr_acc - rd_acc, exact width LW, never exceeds DEPTH and never wraps below 0.
- Pointers: log2(DEPTH) bits each, wrap naturally. Full/empty are decided by level, not by pointer comparison.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both stay set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- flush (highest priority after reset):
  - Next cycle: pointers = 0, level = 0, rd_valid = 0.
  - wr_en and rd_en in the flush cycle are ignored and raise no error flags.
  - rd_data and the error flags are unchanged by flush.
- Reset mid-operation: outputs go to reset values immediately, asynchronously; all buffered data is lost.

Test Plan:
- Reset and fill, DEPTH=4, WIDTH=8:
  - Assert rst_n=0 -> empty=1, level=0, rd_valid=0.
  - Release, then write 8,5,4,3 on consecutive cycles -> level 1,2,3,4; almost_full at level 3; full=1 after the 4th write; overflow=0.
- Drain in order:
  - From full, rd_en for 4 cycles -> rd_data 8,5,4,3 each with rd_valid=1 one cycle after the request.
  - Then empty=1, almost_empty=1 at level<=1.
- Overflow and underflow:
  - Write while full -> write dropped, overflow=1 and stays set.
  - Read while empty -> rd_valid=0, underflow=1.
  - clr_err for one cycle -> both flags 0.
  - clr_err together with an illegal write -> overflow remains 1.
- Simultaneous access:
  - At level 2, wr_en+rd_en for 10 cycles with an incrementing pattern -> level stays 2 and reads return data in order.
  - At full, wr+rd -> level=3 and overflow=1.
  - At empty, wr+rd -> level=1, rd_valid=0, underflow=1.
- Wrap-around: write/read 3*DEPTH+1 words interleaved -> output sequence equals input sequence exactly and level is correct every cycle.
- Flush and async reset:
  - At level 3, flush with wr_en=1 -> level=0, empty=1, error flags unchanged.
  - Pull rst_n low between clock edges -> level=0 and empty=1 before the next edge.
